// File: rtl/fft_r4_sequencer.sv
// Radix-4 FFT address sequencer: per-stage read sweep, drain, and
// delayed write sweep over four banks with ping-pong buffers.
//
// Ports:
//   iCLK, iRESET (sync, active-low), iSTART, iABORT
//   oBANK_RD_ROT / oBANK_WR_ROT : bank rotation for read / write side
//   oADDR_RD_0..3 : per-bank read address
//   oADDR_WR      : write address
//   oADDR_COEF    : twiddle ROM address
//   oWE_A, oWE_B  : ping-pong write enables
//   oSOURCE_DATA  : read buffer select (0 = A, 1 = B)
//   oSTAGE        : current stage index
//   oRDY, oDONE   : idle flag, one-cycle completion pulse
//
// Optional feature macro: FFT_SEQ_ABORT_EN (honours iABORT when defined).

module fft_r4_sequencer #(
  parameter int A_BIT    = 10,
  parameter int PIPE_LAT = 5
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iABORT,
  output logic [1:0]       oBANK_RD_ROT,
  output logic [1:0]       oBANK_WR_ROT,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSOURCE_DATA,
  output logic [3:0]       oSTAGE,
  output logic             oRDY,
  output logic             oDONE
);

  localparam int S = A_BIT / 2 + 1;
  localparam logic [3:0] S_LAST = 4'(S - 1);
  localparam logic [3:0] LAT_MAX = 4'(PIPE_LAT - 1);
  localparam logic [A_BIT-1:0] CNT_MAX = '1;
  localparam logic [A_BIT-1:0] ONE = A_BIT'(1);
  localparam logic [A_BIT-1:0] THREE = A_BIT'(3);

`ifdef FFT_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [A_BIT-1:0] cnt_q, cnt_d;
  logic [3:0]       lat_q, lat_d;
  logic [3:0]       stage_q, stage_d;

  logic abort;
  logic start;

  assign abort = ABORT_EN & iABORT & (state_q != IDLE);
  assign start = (state_q == IDLE) & iSTART;

  // ---- FSM: state register ----
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (iSTART) state_d = READ;
      READ:  if (cnt_q == CNT_MAX) state_d = DRAIN;
      DRAIN: if (lat_q == LAT_MAX)
               state_d = (stage_q == S_LAST) ? DONE : READ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // ---- FSM: outputs ----
  always_comb begin
    oRDY  = (state_q == IDLE);
    oDONE = (state_q == DONE);
  end

  // ---- counters ----
  always_comb begin
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    stage_d = stage_q;
    if (start) begin
      cnt_d   = '0;
      stage_d = '0;
    end
    if (state_q == READ) begin
      cnt_d = cnt_q + ONE;
      lat_d = '0;
    end
    if (state_q == DRAIN) begin
      lat_d = lat_q + 4'd1;
      if (lat_q == LAT_MAX) begin
        cnt_d = '0;
        if (stage_q != S_LAST) stage_d = stage_q + 4'd1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      cnt_q   <= '0;
      lat_q   <= '0;
      stage_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      stage_q <= stage_d;
    end
  end

  // ---- read address generation ----
  // sh = A_BIT - 2s. On stage 0 sh equals A_BIT, so the digit field
  // shifts out entirely: rotation is 0, addresses equal cnt and the
  // coefficient mask keeps all of cnt.
  logic [3:0]       sh2;
  logic [3:0]       sh;
  logic [A_BIT-1:0] fld_m;
  logic [A_BIT-1:0] low_m;
  logic [1:0]       rot_d;
  logic [A_BIT-1:0] coef_d;
  logic [A_BIT-1:0] addr_d [4];

  assign sh2   = {stage_q[2:0], 1'b0};
  assign sh    = 4'(A_BIT) - sh2;
  assign fld_m = THREE << sh;
  assign low_m = (ONE << sh) - ONE;

  always_comb begin
    logic [1:0] bsel;
    bsel   = '0;
    rot_d  = 2'(cnt_q >> sh);
    coef_d = (cnt_q & low_m) << sh2;
    for (int k = 0; k < 4; k++) begin
      bsel      = 2'(k) - rot_d;
      addr_d[k] = (cnt_q & ~fld_m) | (A_BIT'(bsel) << sh);
    end
  end

  logic [1:0]       rot_q;
  logic [A_BIT-1:0] coef_q;
  logic [A_BIT-1:0] addr_q [4];
  logic [A_BIT-1:0] acnt_q;
  logic             vld_q;
  logic             par_q;

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      rot_q  <= '0;
      coef_q <= '0;
      acnt_q <= '0;
      vld_q  <= 1'b0;
      par_q  <= 1'b0;
      for (int k = 0; k < 4; k++) addr_q[k] <= '0;
    end else begin
      if (state_q == READ) begin
        rot_q  <= rot_d;
        coef_q <= coef_d;
        acnt_q <= cnt_q;
        for (int k = 0; k < 4; k++) addr_q[k] <= addr_d[k];
      end
      vld_q <= (state_q == READ) & ~abort;
      par_q <= stage_q[0];
    end
  end

  // ---- write side: aligned read info delayed through the datapath ----
  // Stage parity travels with each beat since the tail of one stage's
  // writes overlaps the start of the next stage's reads.
  logic [A_BIT-1:0] wa_p  [PIPE_LAT];
  logic [1:0]       wr_p  [PIPE_LAT];
  logic             wv_p  [PIPE_LAT];
  logic             wpar_p[PIPE_LAT];

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wa_p[i]   <= '0;
        wr_p[i]   <= '0;
        wv_p[i]   <= 1'b0;
        wpar_p[i] <= 1'b0;
      end
    end else begin
      wa_p[0]   <= acnt_q;
      wr_p[0]   <= rot_q;
      wpar_p[0] <= par_q;
      wv_p[0]   <= vld_q & ~abort;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wa_p[i]   <= wa_p[i-1];
        wr_p[i]   <= wr_p[i-1];
        wpar_p[i] <= wpar_p[i-1];
        wv_p[i]   <= wv_p[i-1] & ~abort;
      end
    end
  end

  assign oBANK_RD_ROT = rot_q;
  assign oADDR_RD_0   = addr_q[0];
  assign oADDR_RD_1   = addr_q[1];
  assign oADDR_RD_2   = addr_q[2];
  assign oADDR_RD_3   = addr_q[3];
  assign oADDR_COEF   = coef_q;
  assign oADDR_WR     = wa_p[PIPE_LAT-1];
  assign oBANK_WR_ROT = wr_p[PIPE_LAT-1];
  assign oWE_B        = wv_p[PIPE_LAT-1] & ~wpar_p[PIPE_LAT-1];
  assign oWE_A        = wv_p[PIPE_LAT-1] & wpar_p[PIPE_LAT-1];
  assign oSOURCE_DATA = stage_q[0];
  assign oSTAGE       = stage_q;

endmodule
